// File: rtl/mix_add_stage.sv
// mix_add_stage: AES round back end. It applies ShiftRows, then MixColumns
// (skipped on the final round), then AddRoundKey. Two registered stages with
// valid/ready handshakes on both sides.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_valid      upstream data qualifier
//   o_ready      stage can accept i_data_in this cycle (combinational)
//   i_data_in    128-bit SubBytes output state
//   i_round_key  128-bit round key, sampled with i_data_in
//   i_last_round 1 = bypass MixColumns, sampled with i_data_in
//   o_valid      o_data_out holds a valid result
//   i_ready      downstream accepts o_data_out this cycle
//   o_data_out   128-bit round result
//
// Byte n of the state (row n%4, column n/4) occupies bits [127-8n -: 8].
module mix_add_stage (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [127:0] i_data_in,
   input  logic [127:0] i_round_key,
   input  logic         i_last_round,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [127:0] o_data_out
);

   localparam int unsigned STATE_W = 128;

   // GF(2^8) multiply by 2, reduced by the AES polynomial
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Output byte (r + 4c) takes input byte (r + 4*((c + r) mod 4))
   function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s);
      logic [STATE_W-1:0] t;
      t = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            t[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
         end
      end
      return t;
   endfunction

   // Column-wise multiply by the circulant {02 03 01 01}
   function automatic logic [STATE_W-1:0] mix_columns(input logic [STATE_W-1:0] s);
      logic [STATE_W-1:0] t;
      logic [7:0] a0, a1, a2, a3;
      t = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 8*(4*c)     -: 8];
         a1 = s[127 - 8*(4*c + 1) -: 8];
         a2 = s[127 - 8*(4*c + 2) -: 8];
         a3 = s[127 - 8*(4*c + 3) -: 8];
         t[127 - 8*(4*c)     -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         t[127 - 8*(4*c + 1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         t[127 - 8*(4*c + 2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         t[127 - 8*(4*c + 3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return t;
   endfunction

   logic [STATE_W-1:0] sr_c;
   logic [STATE_W-1:0] mc_c;
   logic [STATE_W-1:0] s1_next_c;
   logic [STATE_W-1:0] s1_data;
   logic [STATE_W-1:0] s1_key;
   logic               s1_valid;
   logic               load_in_c;
   logic               load_out_c;

   // Round datapath ahead of stage 1
   always_comb begin
      sr_c      = shift_rows(i_data_in);
      mc_c      = mix_columns(sr_c);
      s1_next_c = i_last_round ? sr_c : mc_c;
   end

   // Stage 1 can take a block when it is empty or is handing its block on
   assign o_ready    = !s1_valid || !o_valid || i_ready;
   assign load_in_c  = i_valid && o_ready;
   assign load_out_c = s1_valid && (!o_valid || i_ready);

   // Stage 1: mixed state plus the key captured with it
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_key   <= '0;
      end else if (load_in_c) begin
         s1_valid <= 1'b1;
         s1_data  <= s1_next_c;
         s1_key   <= i_round_key;
      end else if (load_out_c) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: AddRoundKey result, held until the consumer takes it
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid    <= 1'b0;
         o_data_out <= '0;
      end else if (load_out_c) begin
         o_valid    <= 1'b1;
         o_data_out <= s1_data ^ s1_key;
      end else if (o_valid && i_ready) begin
         o_valid    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mix_add_stage.sv
// Testbench for mix_add_stage: directed FIPS-197 vectors, latency, back-to-back,
// backpressure and mid-flight reset, then random traffic against a reference
// model, all checked through an expected-result queue.
module tb_mix_add_stage;

   logic         i_clk;
   logic         i_rst;
   logic         i_valid;
   logic         o_ready;
   logic [127:0] i_data_in;
   logic [127:0] i_round_key;
   logic         i_last_round;
   logic         o_valid;
   logic         i_ready;
   logic [127:0] o_data_out;

   mix_add_stage dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_data_in    (i_data_in),
      .i_round_key  (i_round_key),
      .i_last_round (i_last_round),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_data_out   (o_data_out)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_in  = 0;
   int n_out = 0;
   logic [127:0] exp_q[$];
   bit           hold = 1'b0;
   logic [127:0] hold_data;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   // Generic GF(2^8) shift-and-add multiply
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   // Reference AES round tail on a 4x4 byte matrix
   function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [127:0] k,
                                              input logic last);
      logic [7:0] s[4][4];
      logic [7:0] t[4][4];
      logic [7:0] m[4][4];
      logic [127:0] res;
      for (int n = 0; n < 16; n++) s[n % 4][n / 4] = d[127 - 8*n -: 8];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) t[r][c] = s[r][(c + r) % 4];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            m[r][c] = last ? t[r][c]
                           : gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1) % 4][c])
                             ^ t[(r+2) % 4][c] ^ t[(r+3) % 4][c];
      res = '0;
      for (int n = 0; n < 16; n++) res[127 - 8*n -: 8] = m[n % 4][n / 4];
      return res ^ k;
   endfunction

   // Monitor: observes handshakes mid-cycle, when all signals are settled
   always @(negedge i_clk) begin
      if (i_rst) begin
         exp_q.delete();
         hold  = 1'b0;
         n_in  = 0;
         n_out = 0;
      end else begin
         if (hold) begin
            check("hold_valid", 128'(o_valid), 128'(1));
            check("hold_data", o_data_out, hold_data);
         end
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_out: got %h required no output", o_data_out);
            end else begin
               check("data_out", o_data_out, exp_q.pop_front());
            end
            n_out++;
         end
         if (i_valid && o_ready) begin
            exp_q.push_back(ref_round(i_data_in, i_round_key, i_last_round));
            n_in++;
         end
         hold      = o_valid && !i_ready;
         hold_data = o_data_out;
      end
   end

   localparam logic [127:0] V1_D = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] V1_K = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] V1_R = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] V2_D = 128'he9098972cb31075f3d327d94af2e2cb5;
   localparam logic [127:0] V2_K = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] V2_R = 128'h3925841d02dc09fbdc118597196a0b32;

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [127:0] d, input logic [127:0] k,
                         input logic l);
      i_valid      = v;
      i_data_in    = d;
      i_round_key  = k;
      i_last_round = l;
   endtask

   // Single block with i_ready=1: invisible after one edge, valid after two
   task automatic directed(input string nm, input logic [127:0] d, input logic [127:0] k,
                           input logic l, input logic [127:0] r);
      tick();
      i_ready = 1'b1;
      set_in(1'b1, d, k, l);
      tick();
      i_valid = 1'b0;
      check({nm, "_lat1_valid"}, 128'(o_valid), 128'(0));
      tick();
      check({nm, "_lat2_valid"}, 128'(o_valid), 128'(1));
      check({nm, "_data"}, o_data_out, r);
   endtask

   initial begin
      int idx;
      int out_base;
      bit pend;
      logic [127:0] bd[3];
      logic [127:0] bk[3];
      logic [127:0] pd, pk;
      logic pl;

      i_rst = 1'b1;
      i_ready = 1'b0;
      set_in(1'b0, '0, '0, 1'b0);
      tick();
      tick();
      check("rst_o_valid", 128'(o_valid), 128'(0));
      check("rst_o_data", o_data_out, 128'h0);
      i_rst = 1'b0;
      @(negedge i_clk);
      check("rst_o_ready", 128'(o_ready), 128'(1));

      directed("round1", V1_D, V1_K, 1'b0, V1_R);
      directed("final", V2_D, V2_K, 1'b1, V2_R);

      // Back-to-back at full rate
      tick();
      i_ready = 1'b1;
      set_in(1'b1, V1_D, V1_K, 1'b0);
      @(negedge i_clk);
      check("b2b_ready0", 128'(o_ready), 128'(1));
      tick();
      set_in(1'b1, V2_D, V2_K, 1'b1);
      @(negedge i_clk);
      check("b2b_ready1", 128'(o_ready), 128'(1));
      tick();
      i_valid = 1'b0;
      check("b2b_first_valid", 128'(o_valid), 128'(1));
      check("b2b_first", o_data_out, V1_R);
      tick();
      check("b2b_second_valid", 128'(o_valid), 128'(1));
      check("b2b_second", o_data_out, V2_R);
      repeat (2) tick();

      // Backpressure: three blocks offered over five stalled cycles
      out_base = n_out;
      for (int i = 0; i < 3; i++) begin
         bd[i] = rnd128();
         bk[i] = rnd128();
      end
      idx = 0;
      i_ready = 1'b0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         tick();
         set_in(1'b1, bd[idx], bk[idx], 1'(idx % 2));
         @(negedge i_clk);
         if (o_ready) idx++;
      end
      check("bp_accepted", 128'(idx), 128'(2));
      check("bp_ready_low", 128'(o_ready), 128'(0));
      tick();
      i_ready = 1'b1;
      for (int cyc = 0; cyc < 10 && idx < 3; cyc++) begin
         set_in(1'b1, bd[idx], bk[idx], 1'(idx % 2));
         @(negedge i_clk);
         if (o_ready) idx++;
         tick();
      end
      i_valid = 1'b0;
      repeat (4) tick();
      check("bp_all_out", 128'(n_out - out_base), 128'(3));

      // Reset with both stages full, plus an offer during the reset cycle
      i_ready = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         tick();
         set_in(1'b1, rnd128(), rnd128(), 1'b0);
      end
      tick();
      check("mid_full_valid", 128'(o_valid), 128'(1));
      i_rst = 1'b1;
      set_in(1'b1, rnd128(), rnd128(), 1'b0);
      tick();
      i_rst = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      check("mid_rst_valid", 128'(o_valid), 128'(0));
      check("mid_rst_data", o_data_out, 128'h0);
      check("mid_rst_ready", 128'(o_ready), 128'(1));
      repeat (5) tick();
      check("mid_no_stale", 128'(n_out), 128'(0));

      // Random traffic; upstream holds a block until it is accepted
      pend = 1'b0;
      pd = '0;
      pk = '0;
      pl = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!pend && ($urandom_range(0, 99) < 65)) begin
            pend = 1'b1;
            pd = rnd128();
            pk = rnd128();
            pl = 1'($urandom_range(0, 1));
         end
         set_in(pend, pd, pk, pl);
         i_ready = ($urandom_range(0, 99) < 60);
         @(negedge i_clk);
         if (pend && o_ready) pend = 1'b0;
         tick();
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) tick();
      tick();
      check("rand_queue_empty", 128'(exp_q.size()), 128'(0));
      check("rand_in_eq_out", 128'(n_out), 128'(n_in));

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got timeout required completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

endmodule
